mtc_sl_link_buffer: RTL and testbench

//  Sits directly downstream of the MTC builder. Each clock it takes up to N_IN MTC candidates.
//  The valid flag is the MSB of each candidate. It compacts the valid ones, in index order, into
//  a shared FIFO, then drains one packet per cycle to the sector-logic link over a valid/ready

---
 rtl/mtc_sl_link_buffer_if.sv | 12 +
 rtl/mtc_sl_link_buffer.sv | 68 ++++++
 tb/tb_mtc_sl_link_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mtc_sl_link_buffer_if.sv
// Sector-logic link channel carrying one MTC packet per beat.
// A beat transfers on a rising edge where valid & ready; data is held stable while valid & !ready.
interface mtc_sl_link_buffer_if #(
  parameter int PKT_WIDTH = 32
);
  logic [PKT_WIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mtc_sl_link_buffer.sv
// Compacts valid MTC candidates into a shared FWFT FIFO and drains one packet per cycle
// to the sector-logic link; counts candidates dropped when the FIFO lacks space.
module mtc_sl_link_buffer #(
  parameter int N_IN      = 3,
  parameter int PKT_WIDTH = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PKT_WIDTH-1:0]       mtc_in [N_IN],
  mtc_sl_link_buffer_if.master       sl,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PKT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     rank [N_IN];
  logic [OCC_W-1:0]     k, free, w, drops;
  logic                 not_empty, pop;
  logic [CNT_WIDTH:0]   cnt_sum;

  assign not_empty = (occupancy != '0);
  assign sl.valid  = not_empty;
  assign sl.data   = not_empty ? mem[rd_ptr] : '0;
  assign pop       = not_empty & sl.ready;

  // rank[i] = number of valid candidates below index i; free ignores a same-cycle pop
  always_comb begin
    k = '0;
    for (int i = 0; i < N_IN; i++) begin
      rank[i] = k;
      if (mtc_in[i][PKT_WIDTH-1]) k = k + OCC_W'(1);
    end
    free    = OCC_W'(DEPTH) - occupancy;
    w       = (k < free) ? k : free;
    drops   = k - w;
    cnt_sum = {1'b0, drop_count} + (CNT_WIDTH+1)'(drops);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (mtc_in[i][PKT_WIDTH-1] && (rank[i] < free))
        mem[wr_ptr + rank[i][PTR_W-1:0]] <= mtc_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr    <= wr_ptr + w[PTR_W-1:0];
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      occupancy <= occupancy + w - OCC_W'(pop);
      overflow  <= (drops != '0);
      if (cnt_sum[CNT_WIDTH]) drop_count <= '1;
      else                    drop_count <= cnt_sum[CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mtc_sl_link_buffer.sv
// Randomized bench for mtc_sl_link_buffer against a queue-based model, plus directed checks.
module tb_mtc_sl_link_buffer;
  localparam int N_IN  = 3;
  localparam int PW    = 32;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PW-1:0] mtc_in [N_IN];
  logic          sl_ready;
  logic [4:0]    occupancy, sat_occupancy;
  logic          overflow, sat_overflow;
  logic [15:0]   drop_count;
  logic [3:0]    sat_drop_count;

  mtc_sl_link_buffer_if #(.PKT_WIDTH(PW)) sl_if ();
  mtc_sl_link_buffer_if #(.PKT_WIDTH(PW)) sat_if ();
  assign sl_if.ready  = sl_ready;
  assign sat_if.ready = sl_ready;

  mtc_sl_link_buffer #(.N_IN(N_IN), .PKT_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .mtc_in(mtc_in), .sl(sl_if.master),
    .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count));

  mtc_sl_link_buffer #(.N_IN(N_IN), .PKT_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .mtc_in(mtc_in), .sl(sat_if.master),
    .occupancy(sat_occupancy), .overflow(sat_overflow), .drop_count(sat_drop_count));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a packet queue, a running drop total and an overflow flag
  logic [PW-1:0] exp_q[$];
  int            exp_drops = 0;
  logic          exp_ovf = 1'b0;
  int            m_free, m_k, m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_drops = 0;
      exp_ovf   = 1'b0;
    end else begin
      m_free = DEPTH - exp_q.size();
      if (exp_q.size() != 0 && sl_ready) void'(exp_q.pop_front());
      m_k = 0;
      m_w = 0;
      for (int i = 0; i < N_IN; i++) begin
        if (mtc_in[i][PW-1]) begin
          m_k++;
          if (m_w < m_free) begin
            exp_q.push_back(mtc_in[i]);
            m_w++;
          end
        end
      end
      exp_ovf   = (m_k > m_w);
      exp_drops = exp_drops + (m_k - m_w);
    end
  end

  // per-cycle compare, sampled on the falling edge
  logic cmp_en = 1'b0;
  logic chk_order = 1'b0;
  int   next_out = 100;
  int   out_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sl_valid", sl_if.valid, exp_q.size() != 0);
      check("sl_data", sl_if.data, (exp_q.size() != 0) ? exp_q[0] : '0);
      check("occupancy", occupancy, exp_q.size());
      check("overflow", overflow, exp_ovf);
      check("drop_count", drop_count, (exp_drops > 65535) ? 65535 : exp_drops);
      check("sat_drop_count", sat_drop_count, (exp_drops > 15) ? 15 : exp_drops);
      check("sat_occupancy", sat_occupancy, exp_q.size());
      if (chk_order && sl_if.valid && sl_ready) begin
        check("order", sl_if.data, {1'b1, 31'(next_out)});
        next_out++;
        out_cnt++;
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < N_IN; i++) mtc_in[i] = '0;
  endtask

  function automatic logic [PW-1:0] pkt(input int payload);
    return {1'b1, 31'(payload)};
  endfunction

  task automatic drain();
    clear_in();
    sl_ready = 1'b1;
    for (int c = 0; c < 40 && sl_if.valid; c++) cycle();
    check("drain_empty", sl_if.valid, 1'b0);
  endtask

  initial begin
    clear_in();
    sl_ready = 1'b0;
    cycle();
    cycle();
    check("rst_valid", sl_if.valid, 1'b0);
    check("rst_data", sl_if.data, '0);
    check("rst_occ", occupancy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // compaction: {A, -, C}
    sl_ready = 1'b1;
    mtc_in[0] = pkt('h0A);
    mtc_in[1] = {1'b0, 31'h7FFF};
    mtc_in[2] = pkt('h0C);
    cycle();
    clear_in();
    check("cmp_first", sl_if.data, pkt('h0A));
    cycle();
    check("cmp_second", sl_if.data, pkt('h0C));
    cycle();
    check("cmp_empty", sl_if.valid, 1'b0);

    // backpressure fill to 15, then one more BCID of 3
    sl_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N_IN; i++) mtc_in[i] = pkt(16 + 3 * c + i);
      cycle();
    end
    check("bp_occ15", occupancy, 15);
    for (int i = 0; i < N_IN; i++) mtc_in[i] = pkt(64 + i);
    cycle();
    check("bp_occ16", occupancy, 16);
    check("bp_ovf", overflow, 1'b1);
    check("bp_drop2", drop_count, 2);

    // full with a same-cycle pop: the new candidate is still dropped
    clear_in();
    mtc_in[1] = pkt(80);
    sl_ready = 1'b1;
    cycle();
    check("full_pop_drop3", drop_count, 3);
    check("full_pop_occ15", occupancy, 15);
    drain();

    // async reset mid-cycle with 5 queued
    sl_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) mtc_in[i] = pkt(90 + i);
    cycle();
    clear_in();
    mtc_in[0] = pkt(95);
    mtc_in[1] = pkt(96);
    cycle();
    clear_in();
    check("pre_rst_occ5", occupancy, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", sl_if.valid, 1'b0);
    check("async_rst_occ", occupancy, 0);
    check("async_rst_drop", drop_count, 0);
    cycle();
    rst = 1'b0;

    // wrap/order: 40 packets, random ready, at most one valid per cycle
    begin
      int sent = 0;
      chk_order = 1'b1;
      for (int c = 0; c < 2000 && sent < 40; c++) begin
        sl_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < N_IN; i++) mtc_in[i] = {1'b0, 31'($urandom)};
        if ($urandom_range(0, 1) == 1) begin
          mtc_in[$urandom_range(0, N_IN - 1)] = pkt(100 + sent);
          sent++;
        end
        cycle();
      end
      drain();
      chk_order = 1'b0;
      check("order_count", out_cnt, 40);
      check("order_drop0", drop_count, 0);
    end

    // saturation of the 4-bit counter under sustained overflow
    sl_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N_IN; i++) mtc_in[i] = pkt(200 + 3 * c + i);
      cycle();
    end
    check("sat_main20", drop_count, 20);
    check("sat_hold15", sat_drop_count, 15);
    drain();

    // random mixed traffic
    for (int c = 0; c < 300; c++) begin
      sl_ready = ($urandom_range(0, 99) < 40);
      for (int i = 0; i < N_IN; i++)
        mtc_in[i] = {1'($urandom_range(0, 99) < 60), 31'($urandom)};
      cycle();
    end
    drain();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
